// File: rtl/word_scroll_driver_if.sv
// ---------------------------------------------------------------------------
// word_scroll_driver_if
//   Bundles the run controls, the glyph-ROM read port and the LED panel
//   column/row interface of word_scroll_driver.
//
//   Signals
//     en          run enable                            (controller -> driver)
//     dir         scroll direction, 0 = left, 1 = right (controller -> driver)
//     rom_addr    glyph ROM row address                 (driver -> ROM)
//     rom_data    glyph ROM row, bit 0 = leftmost pixel (ROM -> driver)
//     sdo         serial column data                    (driver -> panel)
//     sclk        shift clock, panel samples on rise    (driver -> panel)
//     slat        one-cycle column latch strobe         (driver -> panel)
//     row_sel     active panel row                      (driver -> panel)
//     row_oe_n    panel output enable, active low       (driver -> panel)
//     frame_tick  one-cycle pulse at end of last row    (driver -> controller)
//     scroll_pos  current window start column           (driver -> controller)
//
//   Modports
//     slave  : the driver side
//     master : the environment side (controller, ROM, panel)
// ---------------------------------------------------------------------------
interface word_scroll_driver_if #(
    parameter int ROWS     = 32,
    parameter int ROW_BITS = 128
);
    localparam int ADDR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int POS_W  = (ROW_BITS > 1) ? $clog2(ROW_BITS) : 1;

    logic                en;
    logic                dir;
    logic [ADDR_W-1:0]   rom_addr;
    logic [0:ROW_BITS-1] rom_data;
    logic                sdo;
    logic                sclk;
    logic                slat;
    logic [ADDR_W-1:0]   row_sel;
    logic                row_oe_n;
    logic                frame_tick;
    logic [POS_W-1:0]    scroll_pos;

    modport slave (
        input  en, dir, rom_data,
        output rom_addr, sdo, sclk, slat, row_sel, row_oe_n, frame_tick, scroll_pos
    );

    modport master (
        output en, dir, rom_data,
        input  rom_addr, sdo, sclk, slat, row_sel, row_oe_n, frame_tick, scroll_pos
    );
endinterface

// File: rtl/word_scroll_driver.sv
// ---------------------------------------------------------------------------
// word_scroll_driver
//   Reads a ROWS x ROW_BITS glyph bitmap ROM one row at a time, cuts a
//   WIN-column window out of each row starting at scroll_pos (wrapping past
//   the last column back to column 0), shifts the window into the panel
//   column registers, latches it, and lights the row for DWELL_CYC cycles.
//   Every SCROLL_FRAMES complete frames the window moves one column.
//
//   Ports
//     clk    in  system clock, rising edge
//     rst_n  in  asynchronous active-low reset
//     bus    word_scroll_driver_if.slave (en, dir, rom_addr, rom_data, sdo,
//            sclk, slat, row_sel, row_oe_n, frame_tick, scroll_pos)
//
//   Row sequence: ADDR (1) -> CAPT (1) -> SHIFT (WIN*2*SCLK_DIV) -> LATCH (1)
//   -> DWELL (DWELL_CYC). All panel outputs are registered decodes of the
//   next state, so they change cleanly on clock edges and drop to their idle
//   values the instant reset asserts.
// ---------------------------------------------------------------------------
module word_scroll_driver #(
    parameter int ROWS          = 32,
    parameter int ROW_BITS      = 128,
    parameter int WIN           = 32,
    parameter int SCLK_DIV      = 2,
    parameter int DWELL_CYC     = 1000,
    parameter int SCROLL_FRAMES = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    word_scroll_driver_if.slave bus
);
    localparam int ADDR_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int POS_W   = (ROW_BITS > 1) ? $clog2(ROW_BITS) : 1;
    localparam int BIT_W   = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int DIV_W   = $clog2(2 * SCLK_DIV);
    localparam int DWELL_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam int FRM_W   = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    localparam logic [ADDR_W-1:0]  ROW_LAST   = ADDR_W'(ROWS - 1);
    localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(ROW_BITS - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(WIN - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(2 * SCLK_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_HIGH   = DIV_W'(SCLK_DIV);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYC - 1);
    localparam logic [FRM_W-1:0]   FRM_LAST   = FRM_W'(SCROLL_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CAPT,
        S_SHIFT,
        S_LATCH,
        S_DWELL
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0]  row_sel_q, row_sel_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [FRM_W-1:0]   frm_q, frm_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [0:WIN-1]     win_q, win_d;
    logic               tick_q, tick_d;
    logic               sdo_q, sdo_d;
    logic               sclk_q, sclk_d;
    logic               slat_q, slat_d;
    logic               oe_n_q, oe_n_d;

    // Window column c comes from ROM column (pos + c) mod ROW_BITS.
    function automatic logic [0:WIN-1] extract_window(input logic [0:ROW_BITS-1] row,
                                                      input logic [POS_W-1:0]    pos);
        logic [0:WIN-1] w;
        int             idx;
        w = '0;
        for (int c = 0; c < WIN; c++) begin
            idx = int'(pos) + c;
            if (idx >= ROW_BITS) begin
                idx = idx - ROW_BITS;
            end
            w[BIT_W'(c)] = row[POS_W'(idx)];
        end
        return w;
    endfunction

    // One-column scroll step, modulo ROW_BITS in either direction.
    function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] pos,
                                                  input logic             dir);
        if (!dir) begin
            return (pos == POS_LAST) ? '0 : pos + 1'b1;
        end
        return (pos == '0) ? POS_LAST : pos - 1'b1;
    endfunction

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        rom_addr_d = rom_addr_q;
        row_sel_d  = row_sel_q;
        pos_d      = pos_q;
        frm_d      = frm_q;
        bit_d      = bit_q;
        div_d      = div_q;
        dwell_d    = dwell_q;
        win_d      = win_q;
        tick_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                row_d = '0;
                if (bus.en) begin
                    state_d    = S_ADDR;
                    rom_addr_d = '0;
                end
            end

            S_ADDR: begin
                state_d = S_CAPT;
            end

            // rom_data has had a full cycle to settle (or to come out of a
            // registered ROM) since rom_addr was updated on entry to ADDR.
            S_CAPT: begin
                win_d   = extract_window(bus.rom_data, pos_q);
                bit_d   = '0;
                div_d   = '0;
                state_d = S_SHIFT;
            end

            // div counts 2*SCLK_DIV cycles per bit: first half sclk low,
            // second half sclk high.
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_LATCH;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            S_LATCH: begin
                row_sel_d = row_q;
                dwell_d   = '0;
                state_d   = S_DWELL;
            end

            S_DWELL: begin
                if (dwell_q == DWELL_LAST) begin
                    row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    if (row_q == ROW_LAST) begin
                        tick_d = 1'b1;
                        // Frame counter runs 0..SCROLL_FRAMES-1; the frame
                        // that would bring it to SCROLL_FRAMES steps instead.
                        if (frm_q == FRM_LAST) begin
                            frm_d = '0;
                            pos_d = step_pos(pos_q, bus.dir);
                        end else begin
                            frm_d = frm_q + 1'b1;
                        end
                    end
                    if (bus.en) begin
                        state_d    = S_ADDR;
                        rom_addr_d = row_d;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Panel outputs are decoded from the next state so the registered
        // versions line up with state_q.
        sclk_d = (state_d == S_SHIFT) && (div_d >= DIV_HIGH);
        sdo_d  = (state_d == S_SHIFT) ? win_d[bit_d] : 1'b0;
        slat_d = (state_d == S_LATCH);
        oe_n_d = (state_d != S_DWELL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            rom_addr_q <= '0;
            row_sel_q  <= '0;
            pos_q      <= '0;
            frm_q      <= '0;
            bit_q      <= '0;
            div_q      <= '0;
            dwell_q    <= '0;
            tick_q     <= 1'b0;
            sdo_q      <= 1'b0;
            sclk_q     <= 1'b0;
            slat_q     <= 1'b0;
            oe_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            rom_addr_q <= rom_addr_d;
            row_sel_q  <= row_sel_d;
            pos_q      <= pos_d;
            frm_q      <= frm_d;
            bit_q      <= bit_d;
            div_q      <= div_d;
            dwell_q    <= dwell_d;
            tick_q     <= tick_d;
            sdo_q      <= sdo_d;
            sclk_q     <= sclk_d;
            slat_q     <= slat_d;
            oe_n_q     <= oe_n_d;
        end
    end

    // Window shift data is only consumed after a CAPT, so it needs no reset.
    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.sdo        = sdo_q;
    assign bus.sclk       = sclk_q;
    assign bus.slat       = slat_q;
    assign bus.row_sel    = row_sel_q;
    assign bus.row_oe_n   = oe_n_q;
    assign bus.frame_tick = tick_q;
    assign bus.scroll_pos = pos_q;

endmodule

// File: tb/tb_word_scroll_driver.sv
// ---------------------------------------------------------------------------
// tb_word_scroll_driver
//   Drives word_scroll_driver with a random glyph ROM (row 0 seeded with a
//   known pattern) and a reference model of row/frame/scroll counting that
//   predicts the shifted window, latch, dwell, frame ticks and scroll moves.
// ---------------------------------------------------------------------------
module tb_word_scroll_driver;
    localparam int ROWS          = 8;
    localparam int ROW_BITS      = 128;
    localparam int WIN           = 32;
    localparam int SCLK_DIV      = 1;
    localparam int DWELL_CYC     = 4;
    localparam int SCROLL_FRAMES = 2;
    localparam int ROW_PERIOD    = 3 + WIN * 2 * SCLK_DIV + DWELL_CYC;
    localparam int ADDR_W        = $clog2(ROWS);
    localparam int POS_W         = $clog2(ROW_BITS);
    localparam int BIT_W         = $clog2(WIN);

    logic                clk = 1'b0;
    logic                rst_n;
    logic                en;
    logic                dir;
    logic [0:ROW_BITS-1] rom_mem [ROWS];

    word_scroll_driver_if #(.ROWS(ROWS), .ROW_BITS(ROW_BITS)) ifc ();

    assign ifc.en       = en;
    assign ifc.dir      = dir;
    assign ifc.rom_data = rom_mem[ifc.rom_addr];

    word_scroll_driver #(
        .ROWS          (ROWS),
        .ROW_BITS      (ROW_BITS),
        .WIN           (WIN),
        .SCLK_DIV      (SCLK_DIV),
        .DWELL_CYC     (DWELL_CYC),
        .SCROLL_FRAMES (SCROLL_FRAMES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int             n_assert = 0;
    int             n_fail   = 0;
    int             m_row    = 0;
    int             m_frame  = 0;
    int             m_pos    = 0;
    int             tick_total = 0;
    logic [0:WIN-1] last_win;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe one row starting just after its ADDR cycle was sampled and
    // ending at the first sample after its dwell. drop_at >= 1 clears en
    // once that many bits have been clocked out.
    task automatic observe_row(input int drop_at);
        logic [0:WIN-1]    expw;
        logic [0:WIN-1]    got;
        logic [POS_W-1:0]  ix;
        logic [ADDR_W-1:0] rsel;
        logic              psclk;
        int                nbits, nslat, noe, nticks, nposbad, cyc;
        bit                seen_oe, done, exp_tick;
        nbits = 0; nslat = 0; noe = 0; nticks = 0; nposbad = 0; cyc = 0;
        seen_oe = 0; done = 0;
        rsel = '0;
        got  = '0;
        for (int c = 0; c < WIN; c++) begin
            ix = POS_W'((m_pos + c) % ROW_BITS);
            expw[BIT_W'(c)] = rom_mem[ADDR_W'(m_row)][ix];
        end
        psclk = ifc.sclk;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (ifc.sclk && !psclk) begin
                if (nbits < WIN) got[BIT_W'(nbits)] = ifc.sdo;
                nbits++;
                if (nbits == drop_at) en = 1'b0;
            end
            psclk = ifc.sclk;
            if (ifc.slat) nslat++;
            if (!ifc.row_oe_n) begin
                if (!seen_oe) rsel = ifc.row_sel;
                seen_oe = 1;
                noe++;
            end else if (seen_oe) begin
                done = 1;
            end
            if (!done) begin
                if (ifc.frame_tick) nticks++;
                if (ifc.scroll_pos !== POS_W'(m_pos)) nposbad++;
            end
        end
        last_win = got;
        chk("row_done", done, 1);
        chk("row_period", cyc, ROW_PERIOD);
        chk("sclk_edges", nbits, WIN);
        chk("window", got, expw);
        chk("slat_pulses", nslat, 1);
        chk("row_sel", rsel, m_row);
        chk("dwell_cycles", noe, DWELL_CYC);
        chk("tick_midrow", nticks, 0);
        chk("pos_stable", nposbad, 0);

        exp_tick = (m_row == ROWS - 1);
        m_row = (m_row + 1) % ROWS;
        if (exp_tick) begin
            m_frame++;
            if (m_frame == SCROLL_FRAMES) begin
                m_frame = 0;
                m_pos = dir ? (m_pos + ROW_BITS - 1) % ROW_BITS : (m_pos + 1) % ROW_BITS;
            end
        end
        if (!en) m_row = 0;

        chk("frame_tick", ifc.frame_tick, exp_tick);
        chk("scroll_pos", ifc.scroll_pos, m_pos);
        if (en) chk("rom_addr", ifc.rom_addr, m_row);
        else    chk("idle_oe", ifc.row_oe_n, 1);
        if (ifc.frame_tick) tick_total++;
    endtask

    task automatic run_rows(input int n);
        for (int i = 0; i < n; i++) observe_row(-1);
    endtask

    initial begin
        int             bad;
        int             ticks0;
        bit             found;
        logic [0:WIN-1] exp32;

        rst_n = 1'b0;
        en    = 1'b0;
        dir   = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int w = 0; w < ROW_BITS / 32; w++)
                rom_mem[r][w*32 +: 32] = $urandom;
        rom_mem[0][0:31] = 32'hA5A5_0F0F;

        // Reset values, then idle with en low.
        repeat (3) @(negedge clk);
        chk("rst_rom_addr", ifc.rom_addr, 0);
        chk("rst_sdo", ifc.sdo, 0);
        chk("rst_sclk", ifc.sclk, 0);
        chk("rst_slat", ifc.slat, 0);
        chk("rst_row_sel", ifc.row_sel, 0);
        chk("rst_row_oe_n", ifc.row_oe_n, 1);
        chk("rst_frame_tick", ifc.frame_tick, 0);
        chk("rst_scroll_pos", ifc.scroll_pos, 0);
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (ifc.row_oe_n !== 1'b1 || ifc.sclk !== 1'b0 || ifc.slat !== 1'b0 ||
                ifc.sdo !== 1'b0 || ifc.rom_addr !== '0 || ifc.row_sel !== '0 ||
                ifc.frame_tick !== 1'b0 || ifc.scroll_pos !== '0) bad++;
        end
        chk("idle_quiet", bad, 0);

        // First row: known pattern, then scroll right 0 -> 127.
        dir = 1'b1;
        en  = 1'b1;
        @(negedge clk);
        chk("start_addr", ifc.rom_addr, 0);
        observe_row(-1);
        chk("first_row_pattern", last_win, 32'hA5A5_0F0F);
        run_rows(15);
        chk("pos_wrap_down", ifc.scroll_pos, 127);

        // Scroll left 127 -> 0, then right down to 120.
        dir = 1'b0;
        run_rows(16);
        chk("pos_wrap_up", ifc.scroll_pos, 0);
        dir = 1'b1;
        run_rows(128);
        chk("pos_at_120", ifc.scroll_pos, 120);

        // Window wraps across ROM column 127 -> 0.
        ticks0 = tick_total;
        observe_row(-1);
        exp32 = {rom_mem[0][120:127], rom_mem[0][0:23]};
        chk("wrap_window", last_win, exp32);
        run_rows(23);
        chk("ticks_per_3_frames", tick_total - ticks0, 3);

        // en dropped during SHIFT of row 5.
        run_rows(5);
        observe_row(10);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (ifc.row_oe_n !== 1'b1 || ifc.slat !== 1'b0 || ifc.sclk !== 1'b0) bad++;
        end
        chk("idle_after_drop", bad, 0);
        en = 1'b1;
        @(negedge clk);
        chk("restart_addr", ifc.rom_addr, 0);
        run_rows(8);
        chk("frame_kept", ifc.scroll_pos, 118);

        // Async reset in the middle of SHIFT.
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (ifc.sclk) found = 1;
        end
        chk("found_sclk_high", found, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sclk", ifc.sclk, 0);
        chk("mid_rst_slat", ifc.slat, 0);
        chk("mid_rst_oe_n", ifc.row_oe_n, 1);
        chk("mid_rst_pos", ifc.scroll_pos, 0);
        chk("mid_rst_addr", ifc.rom_addr, 0);
        chk("mid_rst_row_sel", ifc.row_sel, 0);
        m_row = 0; m_frame = 0; m_pos = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_addr", ifc.rom_addr, 0);
        run_rows(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
